sram_access_ctrl: RTL and testbench

//  Initiator side of the one-hot wordline SRAM port. Accepts binary-addressed read/write

---
 rtl/sram_access_ctrl_if.sv | 39 +++
 rtl/sram_access_ctrl.sv | 155 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - request/response channel bundle for sram_access_ctrl
//
// Purpose: groups the request (valid/ready) and response (valid/ready) channels
// between a requester and the sram access controller.
// Modports:
//   master : requester side (drives req_*, rsp_ready; observes req_ready, rsp_*)
//   slave  : controller side (observes req_*, rsp_ready; drives req_ready, rsp_*)
// Signals:
//   req_valid/req_ready     request handshake
//   req_we/addr/tag/data    request payload (1 = write)
//   rsp_valid/rsp_ready     response handshake
//   rsp_tag/rsp_data/hit    response payload
interface sram_access_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int TW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [TW-1:0] req_tag;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [TW-1:0] rsp_tag;
  logic [DW-1:0] rsp_data;
  logic          rsp_hit;

  modport master (
    output req_valid, req_we, req_addr, req_tag, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_tag, rsp_data, rsp_hit
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_tag, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_tag, rsp_data, rsp_hit
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - initiator for the one-hot wordline tag/data sram
//
// Purpose: accepts binary-addressed read/write requests, drives the sram for
// exactly one cycle with a one-hot wordline, captures the array output and
// returns it on a response channel held until accepted.
// Optional feature: define TAG_CMP_EN to add the read tag comparator driving
// rsp_hit (writes report hit=1); otherwise rsp_hit is constant 0.
// Ports:
//   clk            rising-edge clock shared with the sram
//   rst_n          asynchronous active-low reset
//   bus            sram_access_ctrl_if.slave request/response channels
//   sram_we        write enable to sram
//   sram_wl        one-hot wordline to sram (2**AW bits)
//   sram_tag_in    tag to sram
//   sram_data_in   data to sram
//   sram_tag_out   tag from sram (combinational in the array)
//   sram_data_out  data from sram (combinational in the array)
module sram_access_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8,
  parameter int TW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_access_ctrl_if.slave bus,
  output logic              sram_we,
  output logic [2**AW-1:0]  sram_wl,
  output logic [TW-1:0]     sram_tag_in,
  output logic [DW-1:0]     sram_data_in,
  input  logic [TW-1:0]     sram_tag_out,
  input  logic [DW-1:0]     sram_data_out
);

  localparam int NWL = 2**AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [TW-1:0] tag_q;
  logic [DW-1:0] data_q;
  logic [TW-1:0] rsp_tag_q;
  logic [DW-1:0] rsp_data_q;

  logic          accept;
  logic          capture;
  logic          req_ready_int;
  logic          rsp_valid_int;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs. Everything sram-facing is zero outside DRIVE, so an
  // asynchronous reset during DRIVE removes the write before the next edge.
  always_comb begin
    state_d       = state_q;
    req_ready_int = 1'b0;
    rsp_valid_int = 1'b0;
    accept        = 1'b0;
    capture       = 1'b0;
    sram_we       = 1'b0;
    sram_wl       = '0;
    sram_tag_in   = '0;
    sram_data_in  = '0;
    case (state_q)
      IDLE: begin
        // Held low while reset is asserted even though the state reads IDLE.
        req_ready_int = rst_n;
        if (bus.req_valid && rst_n) begin
          accept  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        sram_we      = we_q;
        sram_wl      = {{(NWL-1){1'b0}}, 1'b1} << addr_q;
        sram_tag_in  = tag_q;
        sram_data_in = data_q;
        capture      = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        rsp_valid_int = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request registers: sampled only on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      we_q   <= bus.req_we;
      addr_q <= bus.req_addr;
      tag_q  <= bus.req_tag;
      data_q <= bus.req_data;
    end
  end

  // Response registers: the sram bypasses write data to its outputs, so a
  // write echoes the values just written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_tag_q  <= '0;
      rsp_data_q <= '0;
    end else if (capture) begin
      rsp_tag_q  <= sram_tag_out;
      rsp_data_q <= sram_data_out;
    end
  end

`ifdef TAG_CMP_EN
  logic hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
    end else if (capture) begin
      hit_q <= we_q ? 1'b1 : (sram_tag_out == tag_q);
    end
  end

  assign bus.rsp_hit = hit_q;
`else
  assign bus.rsp_hit = 1'b0;
`endif

  assign bus.req_ready = req_ready_int;
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - randomized self-checking bench for sram_access_ctrl
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sram_we;
  logic [15:0] sram_wl;
  logic [3:0]  sram_tag_in;
  logic [7:0]  sram_data_in;
  logic [3:0]  sram_tag_out;
  logic [7:0]  sram_data_out;

  sram_access_ctrl_if #(.AW(4), .DW(8), .TW(4)) bus ();

  sram_access_ctrl #(.AW(4), .DW(8), .TW(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .sram_we       (sram_we),
    .sram_wl       (sram_wl),
    .sram_tag_in   (sram_tag_in),
    .sram_data_in  (sram_data_in),
    .sram_tag_out  (sram_tag_out),
    .sram_data_out (sram_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural sram: 16 rows, combinational read with write bypass.
  logic [3:0] mem_tag  [16];
  logic [7:0] mem_data [16];
  int         bad_wl = 0;

  always_comb begin
    sram_tag_out  = '0;
    sram_data_out = '0;
    for (int i = 0; i < 16; i++) begin
      if (sram_wl[i]) begin
        sram_tag_out  = sram_we ? sram_tag_in  : mem_tag[i];
        sram_data_out = sram_we ? sram_data_in : mem_data[i];
      end
    end
  end

  always @(posedge clk) begin
    if (sram_wl != 16'h0 && !$onehot(sram_wl)) bad_wl++;
    if (sram_we && !$onehot(sram_wl)) bad_wl++;
    if (sram_we) begin
      for (int i = 0; i < 16; i++) begin
        if (sram_wl[i]) begin
          mem_tag[i]  <= sram_tag_in;
          mem_data[i] <= sram_data_in;
        end
      end
    end
  end

  // Reference contents: what every address must hold from the requester's view.
  logic [3:0] ref_tag  [16];
  logic [7:0] ref_data [16];

  int n_vec = 0;
  int n_err = 0;

  bit         pend = 1'b0;
  bit         p_we;
  int         p_addr;
  logic [3:0] p_tag;
  logic [7:0] p_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction, entered and left between edges.
  task automatic do_req(input bit we, input int addr, input logic [3:0] tag,
                        input logic [7:0] data, input int hold);
    logic [3:0]  etag;
    logic [7:0]  edata;
    logic        ehit;
    logic [15:0] ewl;
    bit          got;
    etag  = we ? tag  : ref_tag[addr];
    edata = we ? data : ref_data[addr];
`ifdef TAG_CMP_EN
    ehit  = we ? 1'b1 : (ref_tag[addr] == tag);
`else
    ehit  = 1'b0;
`endif
    ewl   = 16'h1 << addr;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr[3:0];
    bus.req_tag   = tag;
    bus.req_data  = data;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("req_accept", got, 1);
    if (!got) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request inputs: the in-flight access must not see them.
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = 4'($urandom);
    bus.req_tag   = 4'($urandom);
    bus.req_data  = 8'($urandom);
    if (we) begin
      ref_tag[addr]  = tag;
      ref_data[addr] = data;
    end
    @(negedge clk);
    chk("drive_wl", sram_wl, ewl);
    chk("drive_we", sram_we, we);
    chk("drive_tag_in", sram_tag_in, tag);
    chk("drive_data_in", sram_data_in, data);
    chk("drive_rsp_valid", bus.rsp_valid, 0);
    chk("drive_req_ready", bus.req_ready, 0);
    @(negedge clk);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_tag", bus.rsp_tag, etag);
    chk("rsp_data", bus.rsp_data, edata);
    chk("rsp_hit", bus.rsp_hit, ehit);
    chk("resp_wl_idle", sram_wl, 0);
    chk("resp_we_idle", sram_we, 0);
    chk("resp_req_ready", bus.req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      if (h == 0 && pend) begin
        bus.req_valid = 1'b1;
        bus.req_we    = p_we;
        bus.req_addr  = p_addr[3:0];
        bus.req_tag   = p_tag;
        bus.req_data  = p_data;
        pend = 1'b0;
      end
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_tag", bus.rsp_tag, etag);
      chk("hold_rsp_data", bus.rsp_data, edata);
      chk("hold_rsp_hit", bus.rsp_hit, ehit);
      chk("hold_req_ready", bus.req_ready, 0);
      chk("hold_we", sram_we, 0);
      chk("hold_wl", sram_wl, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
    chk("post_wl", sram_wl, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_tag[i]  = 4'h0;
      mem_data[i] = 8'h00;
      ref_tag[i]  = 4'h0;
      ref_data[i] = 8'h00;
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_wl", sram_wl, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_rsp_hit", bus.rsp_hit, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", bus.req_ready, 1);
    @(negedge clk);

    // Reset during DRIVE drops the write
    do_req(1'b1, 5, 4'h3, 8'h11, 0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'd5;
    bus.req_tag   = 4'hF;
    bus.req_data  = 8'hAA;
    chk("t1_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t1_drive_we", sram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_we", sram_we, 0);
    chk("t1_rst_wl", sram_wl, 0);
    chk("t1_rst_req_ready", bus.req_ready, 0);
    chk("t1_rst_rsp_valid", bus.rsp_valid, 0);
    chk("t1_rst_rsp_tag", bus.rsp_tag, 0);
    chk("t1_rst_rsp_data", bus.rsp_data, 0);
    chk("t1_rst_rsp_hit", bus.rsp_hit, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_rst_hold_rsp_valid", bus.rsp_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("t1_rel_req_ready", bus.req_ready, 1);
    @(negedge clk);
    do_req(1'b0, 5, 4'h3, 8'h00, 0);

    // Write then read addr 3
    do_req(1'b1, 3, 4'h9, 8'h5C, 0);
    do_req(1'b0, 3, 4'h9, 8'h00, 0);
    do_req(1'b0, 3, 4'h4, 8'h00, 1);

    // All addresses: data = addr*17, tag = ~addr
    for (int a = 0; a < 16; a++) do_req(1'b1, a, ~a[3:0], 8'(a * 17), 0);
    for (int a = 0; a < 16; a++) do_req(1'b0, a, ~a[3:0], 8'h00, 0);

    // Backpressure with a request pending behind the response
    pend   = 1'b1;
    p_we   = 1'b1;
    p_addr = 7;
    p_tag  = 4'h2;
    p_data = 8'hC3;
    do_req(1'b0, 3, 4'h9, 8'h00, 5);
    chk("bp_pending_still_valid", bus.req_valid, 1);
    do_req(1'b1, 7, 4'h2, 8'hC3, 0);
    do_req(1'b0, 7, 4'h2, 8'h00, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      bit         w;
      int         a;
      logic [3:0] t;
      w = ($urandom_range(0, 2) == 0);
      a = int'($urandom_range(0, 15));
      t = ($urandom_range(0, 1) == 0) ? ref_tag[a] : 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        pend   = 1'b1;
        p_we   = 1'($urandom);
        p_addr = int'($urandom_range(0, 15));
        p_tag  = 4'($urandom);
        p_data = 8'($urandom);
        do_req(w, a, t, 8'($urandom), int'($urandom_range(1, 4)));
        do_req(p_we, p_addr, p_tag, p_data, 0);
      end else begin
        do_req(w, a, t, 8'($urandom), int'($urandom_range(0, 3)));
      end
    end

    chk("onehot_violations", bad_wl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
